// File: rtl/lc330_prog_loader.sv
// Program loader for the LC330 core: packs a byte-stream image into 32-bit words,
// writes instruction memory and holds the core in reset until the load succeeds.
// Optional feature macro: LC330_LOADER_CHECKSUM_EN (trailing mod-256 payload checksum byte).
module lc330_prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LOAD,
`ifdef LC330_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERR
  } state_e;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [23:0]       buf_q, buf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef LC330_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] n_full;
  logic        last_word;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_LOAD: in_ready = ~rst;
`ifdef LC330_LOADER_CHECKSUM_EN
      S_CSUM:                 in_ready = ~rst;
`endif
      default:                in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign n_full    = {in_data, n_q[7:0]};
  assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, n_q};

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    buf_d      = buf_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LC330_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_HDR0: if (accept) begin
        n_d[7:0] = in_data;
        state_d  = S_HDR1;
      end
      S_HDR1: if (accept) begin
        n_d[15:8] = in_data;
        if (n_full == 16'd0)               state_d = S_RUN;
        else if ({1'b0, n_full} > CAP)     state_d = S_ERR;
        else begin
          state_d    = S_LOAD;
          byte_idx_d = 2'd0;
          word_cnt_d = '0;
`ifdef LC330_LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end
      S_LOAD: if (accept) begin
        byte_idx_d = byte_idx_q + 2'd1;
        buf_d      = {in_data, buf_q[23:8]};
`ifdef LC330_LOADER_CHECKSUM_EN
        csum_d     = csum_q + in_data;
`endif
        if (byte_idx_q == 2'd3) begin
          // Word completes on this byte; the write strobe is the following cycle.
          we_d       = 1'b1;
          addr_d     = word_cnt_q[ADDR_W-1:0];
          wdata_d    = {in_data, buf_q};
          word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
          if (last_word) begin
`ifdef LC330_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_RUN;
`endif
          end
        end
      end
`ifdef LC330_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) state_d = (in_data == csum_q) ? S_RUN : S_ERR;
`endif
      S_RUN:  if (start) state_d = S_HDR0;
      S_ERR:  if (start) state_d = S_HDR0;
      default: state_d = S_HDR0;
    endcase
    done_d    = (state_d == S_RUN);
    error_d   = (state_d == S_ERR);
    // Keyed on the current state so the release lands one cycle after the last write pulse.
    cpu_rst_d = ~((state_q == S_RUN) & ~start);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HDR0;
      n_q        <= 16'd0;
      byte_idx_q <= 2'd0;
      word_cnt_q <= '0;
      buf_q      <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LC330_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      buf_q      <= buf_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LC330_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // A strobe registered just before reset must not reach memory during the reset cycle.
  assign imem_we    = we_q & ~rst;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_lc330_prog_loader.sv
// Scoreboard bench for lc330_prog_loader: the byte driver models expected writes,
// a negedge monitor pops and compares every imem_we pulse (address, data, cycle).
module tb_lc330_prog_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst, in_valid, start, in_ready;
  logic [7:0]        in_data;
  logic              imem_we, cpu_rst, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit start_in_gaps = 1'b0;

  logic [7:0]        img[$];
  logic [31:0]       words[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  int                exp_cyc[$];

  lc330_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_addr.size() == 0) chk("unexpected_we", 64'd1, 64'd0);
      else begin
        chk("we_addr",  64'(imem_addr),  64'(exp_addr.pop_front()));
        chk("we_data",  64'(imem_wdata), 64'(exp_data.pop_front()));
        chk("we_cycle", 64'(cyc),        64'(exp_cyc.pop_front()));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
    bit rdy;
    int tries = 0;
    acc_cyc = -1;
    repeat (gap) begin
      start = start_in_gaps;
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin acc_cyc = cyc; break; end
      tries++;
      if (tries > 200) begin chk("accept_timeout", 64'd0, 64'd1); break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_img(input int count, input int gap);
    int n, ac;
    n = {img[1], img[0]};
    for (int i = 0; i < count; i++) begin
      send_byte(img[i], gap, ac);
      if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
        exp_addr.push_back(ADDR_W'((i - 2) / 4));
        exp_data.push_back({img[i], img[i-1], img[i-2], img[i-3]});
        exp_cyc.push_back(ac);
      end
    end
  endtask

  task automatic build(input int n);
    logic [7:0] s = 8'd0;
    logic [15:0] n16 = 16'(n);
    img.delete();
    img.push_back(n16[7:0]);
    img.push_back(n16[15:8]);
    foreach (words[k]) for (int b = 0; b < 4; b++) begin
      img.push_back(words[k][8*b +: 8]);
      s = s + words[k][8*b +: 8];
    end
`ifdef LC330_LOADER_CHECKSUM_EN
    if (words.size() > 0) img.push_back(s);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Ends in RUN at the cycle after the last accepted byte; release follows one cycle later.
  task automatic expect_run(input string tag);
    chk({tag, "_done"},    64'(done),    64'd1);
    chk({tag, "_cpurst1"}, 64'(cpu_rst), 64'd1);
    @(negedge clk);
    chk({tag, "_cpurst0"}, 64'(cpu_rst), 64'd0);
    chk({tag, "_rdy"},     64'(in_ready), 64'd0);
    chk({tag, "_err"},     64'(error),   64'd0);
    chk({tag, "_drain"},   64'(exp_addr.size()), 64'd0);
  endtask

  task automatic load_image_a();
    words.delete();
    words.push_back(32'h0040_0001);
    words.push_back(32'h0080_0002);
    build(2);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
    // 1. reset
    repeat (2) @(negedge clk);
    chk("rst_rdy_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cpurst", 64'(cpu_rst),  64'd1);
    chk("rst_rdy",    64'(in_ready), 64'd1);
    chk("rst_we",     64'(imem_we),  64'd0);
    chk("rst_done",   64'(done),     64'd0);
    chk("rst_err",    64'(error),    64'd0);

    // 2. back-to-back image
    load_image_a();
    send_img(img.size(), 0);
    expect_run("t2");
    pulse_start();
    chk("t2_restart_cpurst", 64'(cpu_rst),  64'd1);
    chk("t2_restart_rdy",    64'(in_ready), 64'd1);
    chk("t2_restart_done",   64'(done),     64'd0);

    // 3. valid toggling, with stray start pulses that must be ignored mid-load
    start_in_gaps = 1'b1;
    send_img(img.size(), 1);
    start_in_gaps = 1'b0;
    expect_run("t3");
    pulse_start();

    // 4. oversize count
    words.delete();
    build(257);
    send_img(img.size(), 0);
    chk("t4_err",    64'(error),    64'd1);
    chk("t4_rdy",    64'(in_ready), 64'd0);
    chk("t4_cpurst", 64'(cpu_rst),  64'd1);
    chk("t4_done",   64'(done),     64'd0);
    pulse_start();
    chk("t4_clr_err", 64'(error),    64'd0);
    chk("t4_clr_rdy", 64'(in_ready), 64'd1);

    // N == 0: straight to RUN, no writes
    build(0);
    send_img(img.size(), 0);
    expect_run("n0");
    pulse_start();

    // Full capacity: N == 2**ADDR_W
    words.delete();
    for (int k = 0; k < (1 << ADDR_W); k++) words.push_back($urandom);
    build(1 << ADDR_W);
    send_img(img.size(), 0);
    expect_run("full");
    pulse_start();

`ifdef LC330_LOADER_CHECKSUM_EN
    // 5. checksum mismatch then match
    words.delete();
    words.push_back(32'h0000_0006);
    build(1);
    img[img.size()-1] = 8'h07;
    send_img(img.size(), 0);
    chk("t5_err",    64'(error),   64'd1);
    chk("t5_cpurst", 64'(cpu_rst), 64'd1);
    @(negedge clk);
    chk("t5_cpurst_hold", 64'(cpu_rst), 64'd1);
    chk("t5_drain", 64'(exp_addr.size()), 64'd0);
    pulse_start();
    build(1);
    send_img(img.size(), 0);
    expect_run("t5ok");
    pulse_start();
`endif

    // 6. reset mid-load after 5 payload bytes, then full reload
    load_image_a();
    send_img(7, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_rdy", 64'(in_ready), 64'd0);
    chk("t6_rst_we",  64'(imem_we),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_drain", 64'(exp_addr.size()), 64'd0);
    @(negedge clk);
    chk("t6_cpurst", 64'(cpu_rst), 64'd1);
    send_img(img.size(), 0);
    expect_run("t6");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
